// File: rtl/riscv_pkg.sv
// Shared types for the RV32I fetch front end.
//   XLEN          : architectural register / address width
//   INSTR_NOP     : canonical nop (addi x0, x0, 0)
//   fetch_state_e : prefetch sequencer states
//   fetch_entry_t : one buffered fetch, {pc, instr}
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Bus bundle between the prefetch unit and its neighbours.
//   imem_req_*     : in-order word fetch requests to instruction memory
//   imem_rsp_*     : in-order responses from instruction memory
//   redirect_*     : taken branch / jump target from execute
//   dec_*          : {pc, instr} handshake towards decode
// modport master : prefetch unit side
// modport slave  : environment side (imem, execute, decode)
interface instr_prefetch_unit_if
  import riscv_pkg::*;
();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch buffer.
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   push/din   : write one entry (caller guarantees not full)
//   pop        : consume head entry (caller guarantees not empty)
//   flush      : empty the FIFO; wins over push, a same-cycle pop is absorbed
//   head       : current head entry, meaningful only when !empty
//   empty      : no entries held
//   count      : number of entries held (0..DEPTH)
module prefetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               din,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage carries no reset; the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch stage of the RV32I core. Owns the PC, issues in-order word requests
// to instruction memory, buffers returned words in prefetch_fifo and hands
// {pc, instr} to decode. A redirect flushes the buffer and drops responses
// still in flight for the old stream.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (master) : imem request/response, redirect, decode handshake
//   fetch_fault  : sticky misaligned-redirect flag
// Build option: FETCH_MISALIGN_CHECK_EN -- a redirect to a non word-aligned
// target raises fetch_fault and parks the unit in HALT until reset. Without
// it, redirect targets are forced word-aligned and fetch_fault stays 0.
module instr_prefetch_unit
  import riscv_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MAX_OUTST = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_prefetch_unit_if.master bus,
  output logic                  fetch_fault
);

  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   drop;

  logic            req_valid;
  logic            req_fire;
  logic            credit_ok;
  logic [OW-1:0]   outst_net;
  logic [OW-1:0]   outst_nxt;
  logic            rsp_drop;
  logic            rsp_push;
  logic            redirect_take;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_q;

  fetch_entry_t    fifo_din;
  fetch_entry_t    fifo_head;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            fifo_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign;
  logic fault_q;

  assign redir_pc    = bus.redirect_pc;
  assign misalign    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00) && (state != HALT);
  assign fetch_fault = fault_q;
`else
  assign redir_pc    = bus.redirect_pc & ~32'h3;
  assign fetch_fault = 1'b0;
`endif

  // Every buffered or in-flight fetch owns a FIFO slot, so a response can
  // always be pushed without checking for full.
  assign credit_ok = (int'(fifo_count) + int'(outst)) < DEPTH;
  assign req_fire  = req_valid && bus.imem_req_ready;

  // Requests never fire in a redirect cycle, so the post-redirect in-flight
  // count depends only on a same-cycle response.
  assign outst_net = outst - OW'(bus.imem_rsp_valid);
  assign outst_nxt = outst_net + OW'(req_fire);

  assign redirect_take = bus.redirect_valid && (state != HALT);
  assign rsp_drop      = bus.imem_rsp_valid && (drop != '0);
  assign rsp_push      = bus.imem_rsp_valid && (drop == '0) && (state != HALT);

  // Live requests are always a contiguous run ending at fetch_pc: nothing is
  // issued until every stale response has been dropped.
  assign pc_q = fetch_pc - (32'(outst) << 2);

  assign fifo_din = '{pc: pc_q, instr: bus.imem_rsp_data};
  assign fifo_pop = bus.dec_valid && bus.dec_ready;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (bus.redirect_valid),
    .head  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    unique case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        req_valid = (int'(outst) < MAX_OUTST) && credit_ok && !bus.redirect_valid;
        if (bus.redirect_valid && (outst_net != '0)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.redirect_valid) state_nxt = (outst_net != '0) ? DRAIN : FETCH;
        else if (drop == '0)    state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (misalign) begin
      state_nxt = HALT;
      req_valid = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect_take) begin
        fetch_pc <= redir_pc;
        drop     <= outst_net;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        drop <= drop - OW'(rsp_drop);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fault_q <= 1'b0;
    else if (misalign) fault_q <= 1'b1;
  end
`endif

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.dec_valid      = !fifo_empty;
  assign bus.dec_instr      = fifo_empty ? 32'h0 : fifo_head.instr;
  assign bus.dec_pc         = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a behavioural in-order imem of
// programmable latency and a decode-side pop log.
module tb_instr_prefetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic fetch_fault;

  always #5 clk = ~clk;

  instr_prefetch_unit_if bus ();

  instr_prefetch_unit #(
    .DEPTH     (4),
    .RESET_PC  (32'h0),
    .MAX_OUTST (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fetch_fault (fetch_fault)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        q[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];
  logic [31:0] exp_req_addr = 32'h0;
  int          chk_idx = 0;
  logic [31:0] chk_pc  = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // imem model and decode log; decisions made mid-cycle for the next edge.
  always @(negedge clk) begin
    req_t r;
    if (rst) begin
      q.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(q[0].addr);
        void'(q.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        r.addr = bus.imem_req_addr;
        r.due  = cyc + 1 + lat;
        q.push_back(r);
        exp_req_addr = bus.imem_req_addr + 32'd4;
      end
      if (bus.dec_valid && bus.dec_ready) begin
        log_pc.push_back(bus.dec_pc);
        log_instr.push_back(bus.dec_instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect_pc    = pc;
    bus.redirect_valid = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  task automatic check_stream(input string name, input int min_new);
    int n;
    n = log_pc.size() - chk_idx;
    if (min_new > 0) begin
      checks++;
      if (n < min_new) begin
        failures++;
        $display("FAIL %s_count got=%0d need>=%0d", name, n, min_new);
      end
    end
    while (chk_idx < log_pc.size()) begin
      checks++;
      if (log_pc[chk_idx] !== chk_pc || log_instr[chk_idx] !== mem_word(chk_pc)) begin
        failures++;
        $display("FAIL %s_entry%0d got pc=%h instr=%h need pc=%h instr=%h", name, chk_idx,
                 log_pc[chk_idx], log_instr[chk_idx], chk_pc, mem_word(chk_pc));
      end
      chk_idx++;
      chk_pc += 32'd4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b need=0", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr got=%h need=0", bus.imem_req_addr); end
    checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL rst_dec_valid got=%b need=0", bus.dec_valid); end
    checks++; if (bus.dec_instr !== 32'h0 || bus.dec_pc !== 32'h0) begin failures++; $display("FAIL rst_dec_data got=%h/%h need=0/0", bus.dec_pc, bus.dec_instr); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b need=0", fetch_fault); end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL boot_idle got=%b need=0", bus.imem_req_valid); end
    step();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL first_req got valid=%b addr=%h need valid=1 addr=0", bus.imem_req_valid, bus.imem_req_addr);
    end
    repeat (25) step();
    check_stream("stream", 8);
  endtask

  task automatic test_backpressure();
    bus.dec_ready = 1'b0;
    repeat (10) step();
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b need=0", bus.imem_req_valid); end
    checks++; if (dut.u_fifo.count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d need=4", dut.u_fifo.count); end
    checks++; if (bus.dec_valid !== 1'b1) begin failures++; $display("FAIL bp_dec_valid got=%b need=1", bus.dec_valid); end
    bus.dec_ready = 1'b1;
    repeat (20) step();
    check_stream("backpressure", 8);
  endtask

  task automatic test_req_stall();
    bus.imem_req_ready = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_req_addr || dut.outst !== 2'd0) begin
        failures++;
        $display("FAIL stall_cyc%0d got valid=%b addr=%h outst=%0d need valid=1 addr=%h outst=0",
                 i, bus.imem_req_valid, bus.imem_req_addr, dut.outst, exp_req_addr);
      end
    end
    bus.imem_req_ready = 1'b1;
    repeat (20) step();
    check_stream("req_stall", 4);
  endtask

  task automatic test_redirect_drain();
    int i;
    lat = 3;
    for (i = 0; i < 40 && !(q.size() == 2 && q[0].due != cyc + 1); i++) step();
    checks++;
    if (!(q.size() == 2 && q[0].due != cyc + 1)) begin
      failures++; $display("FAIL drain_setup got inflight=%0d need=2", q.size());
    end
    do_redirect(32'h40);
    check_stream("pre_drain", 0);
    checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL drain_flush got=%b need=0", bus.dec_valid); end
    checks++; if (dut.drop !== 2'd2) begin failures++; $display("FAIL drain_drop got=%0d need=2", dut.drop); end
    chk_pc = 32'h40;
    repeat (30) step();
    checks++; if (dut.drop !== 2'd0) begin failures++; $display("FAIL drain_drop_end got=%0d need=0", dut.drop); end
    check_stream("redirect_drain", 4);
  endtask

  task automatic test_redirect_rsp_pop();
    int i, n0, exp_drop;
    lat = 1;
    repeat (6) step();
    for (i = 0; i < 40 && !(q.size() > 0 && q[0].due == cyc + 1 && bus.dec_valid); i++) step();
    checks++;
    if (!(q.size() > 0 && q[0].due == cyc + 1 && bus.dec_valid)) begin
      failures++; $display("FAIL rsp_pop_setup got inflight=%0d dec_valid=%b need >=1 and 1", q.size(), bus.dec_valid);
    end
    exp_drop = q.size() - 1;
    n0 = log_pc.size();
    do_redirect(32'h80);
    checks++; if (log_pc.size() !== n0 + 1) begin failures++; $display("FAIL rsp_pop_popped got=%0d need=%0d", log_pc.size(), n0 + 1); end
    checks++; if (int'(dut.drop) !== exp_drop) begin failures++; $display("FAIL rsp_pop_drop got=%0d need=%0d", dut.drop, exp_drop); end
    checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL rsp_pop_flush got=%b need=0", bus.dec_valid); end
    check_stream("pre_rsp_pop", 0);
    chk_pc = 32'h80;
    repeat (20) step();
    checks++; if (dut.drop !== 2'd0) begin failures++; $display("FAIL rsp_pop_drop_end got=%0d need=0", dut.drop); end
    check_stream("redirect_rsp_pop", 4);
  endtask

  task automatic test_misalign();
    int n0;
    repeat (3) step();
    do_redirect(32'h42);
    check_stream("pre_misalign", 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    n0 = log_pc.size();
    checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL misalign_fault got=%b need=1", fetch_fault); end
    checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL misalign_dec_valid got=%b need=0", bus.dec_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL misalign_req_cyc%0d got=%b need=0", i, bus.imem_req_valid); end
      step();
    end
    checks++; if (log_pc.size() !== n0) begin failures++; $display("FAIL misalign_pops got=%0d need=%0d", log_pc.size(), n0); end
`else
    n0 = 0;
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL misalign_fault got=%b need=0", fetch_fault); end
    chk_pc = 32'h40 + 32'(n0);
    repeat (20) step();
    check_stream("misalign_resume", 4);
`endif
  endtask

  task automatic test_reset_midstream();
    repeat (4) step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.dec_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_valids got req=%b dec=%b need 0/0", bus.imem_req_valid, bus.dec_valid);
    end
    checks++; if (bus.imem_req_addr !== 32'h0 || fetch_fault !== 1'b0 || dut.outst !== 2'd0) begin
      failures++; $display("FAIL midrst_state got addr=%h fault=%b outst=%0d need 0/0/0", bus.imem_req_addr, fetch_fault, dut.outst);
    end
    step();
    rst = 1'b0;
    chk_idx = log_pc.size();
    chk_pc  = 32'h0;
    step();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL midrst_restart got valid=%b addr=%h need 1/0", bus.imem_req_valid, bus.imem_req_addr);
    end
    repeat (20) step();
    check_stream("after_reset", 4);
  endtask

  initial begin
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_drain();
    test_redirect_rsp_pop();
    test_misalign();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
